// File: rtl/sy_ppl_qdec_blk.sv
// Fetch-block quick decoder: finds RVI/RVC boundaries, classifies, computes targets, registered output.
// Optional straddle buffer for 32-bit instructions split across blocks: define SY_QDEC_STRADDLE_EN.
package sy_pkg;
  parameter int AWTH = 32;
  parameter int IWTH = 32;
  parameter int DWTH = 32;
  typedef enum logic [2:0] {
    QDEC_NORMAL,
    QDEC_BRANCH,
    QDEC_JUMP,
    QDEC_JALR,
    QDEC_CALL_JAL,
    QDEC_CALL_JALR,
    QDEC_RET
  } qdec_type_e;
endpackage

module sy_ppl_qdec_blk
  import sy_pkg::*;
#(
  parameter int FETCH_HW = 4
) (
  input  logic                                clk_i,
  input  logic                                rst_i,
  input  logic                                flush_i,
  input  logic                                fetch_vld_i,
  output logic                                fetch_rdy_o,
  input  logic [16*FETCH_HW-1:0]              fetch_data_i,
  input  logic [AWTH-1:0]                     fetch_vaddr_i,
  output logic                                out_vld_o,
  input  logic                                out_rdy_i,
  output logic [FETCH_HW-1:0]                 slot_vld_o,
  output logic [FETCH_HW-1:0][IWTH-1:0]       slot_instr_o,
  output logic [FETCH_HW-1:0][AWTH-1:0]       slot_pc_o,
  output logic [FETCH_HW-1:0]                 slot_is_c_o,
  output logic [FETCH_HW-1:0]                 slot_imm_neg_o,
  output qdec_type_e [FETCH_HW-1:0]           slot_type_o,
  output logic [FETCH_HW-1:0][AWTH-1:0]       slot_target_o,
  output logic                                cf_vld_o,
  output logic [$clog2(FETCH_HW)-1:0]         cf_idx_o,
  output logic                                partial_o
);

  localparam int OFFW = $clog2(FETCH_HW);

  function automatic qdec_type_e qdec_cls(input logic [IWTH-1:0] ins, input logic is_c);
    qdec_type_e t;
    logic       rs1_lnk;
    logic       rd_lnk;
    t       = QDEC_NORMAL;
    rs1_lnk = 1'b0;
    rd_lnk  = (ins[11:7] == 5'd1) || (ins[11:7] == 5'd5);
    if (is_c) begin
      rs1_lnk = rd_lnk;
      if (ins[1:0] == 2'b10 && ins[15:13] == 3'b100 && ins[11:7] != 5'd0 && ins[6:2] == 5'd0) begin
        if (ins[12])      t = QDEC_CALL_JALR;
        else if (rs1_lnk) t = QDEC_RET;
        else              t = QDEC_JALR;
      end else if (ins[1:0] == 2'b01 && ins[15:13] == 3'b101) begin
        t = QDEC_JUMP;
      end else if (ins[1:0] == 2'b01 && ins[15:14] == 2'b11) begin
        t = QDEC_BRANCH;
      end
    end else begin
      rs1_lnk = (ins[19:15] == 5'd1) || (ins[19:15] == 5'd5);
      case (ins[6:0])
        7'b1100111: if (ins[14:12] == 3'b000) begin
          if (rd_lnk)       t = QDEC_CALL_JALR;
          else if (rs1_lnk) t = QDEC_RET;
          else              t = QDEC_JALR;
        end
        7'b1101111: t = rd_lnk ? QDEC_CALL_JAL : QDEC_JUMP;
        7'b1100011: t = QDEC_BRANCH;
        default:    t = QDEC_NORMAL;
      endcase
    end
    return t;
  endfunction

  function automatic logic [DWTH-1:0] qdec_imm(input logic [IWTH-1:0] i, input logic is_c);
    if (is_c) begin
      if (i[15:13] == 3'b101)
        return {{(DWTH-11){i[12]}}, i[8], i[10:9], i[6], i[7], i[2], i[11], i[5:3], 1'b0};
      return {{(DWTH-8){i[12]}}, i[6:5], i[2], i[11:10], i[4:3], 1'b0};
    end
    if (i[6:0] == 7'b1101111)
      return {{(DWTH-20){i[31]}}, i[19:12], i[20], i[30:21], 1'b0};
    return {{(DWTH-12){i[31]}}, i[7], i[30:25], i[11:8], 1'b0};
  endfunction

  logic                         accept;
  logic [OFFW-1:0]              ent_off;
  logic [AWTH-1:0]              base;
  logic [16*(FETCH_HW+1)-1:0]   dext;
  logic                         sj_vld;
  logic [15:0]                  sj_hw;
  logic [AWTH-1:0]              sj_pc;

  logic [FETCH_HW-1:0]             vld_d, is_c_d, neg_d;
  logic [FETCH_HW-1:0][IWTH-1:0]   instr_d;
  logic [FETCH_HW-1:0][AWTH-1:0]   pc_d, tgt_d;
  qdec_type_e [FETCH_HW-1:0]       typ_d;
  logic                            partial_d, cf_vld_d;
  logic [OFFW-1:0]                 cf_idx_d;
  logic [OFFW:0]                   cur;
  logic [15:0]                     hw;
  logic [DWTH-1:0]                 imm;
  logic                            has_tgt;

  logic [FETCH_HW-1:0]             vld_q, is_c_q, neg_q;
  logic [FETCH_HW-1:0][IWTH-1:0]   instr_q;
  logic [FETCH_HW-1:0][AWTH-1:0]   pc_q, tgt_q;
  qdec_type_e [FETCH_HW-1:0]       typ_q;
  logic                            out_vld_q, partial_q, cf_vld_q;
  logic [OFFW-1:0]                 cf_idx_q;

  assign fetch_rdy_o = !out_vld_q || out_rdy_i;
  assign accept      = fetch_vld_i && fetch_rdy_o;
  assign ent_off     = fetch_vaddr_i[OFFW:1];
  assign base        = {fetch_vaddr_i[AWTH-1:OFFW+1], {OFFW{1'b0}}, fetch_vaddr_i[0]};
  assign dext        = {16'h0000, fetch_data_i};

`ifdef SY_QDEC_STRADDLE_EN
  logic            pend_q;
  logic [15:0]     sv_hw_q;
  logic [AWTH-1:0] sv_pc_q;

  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      pend_q  <= 1'b0;
      sv_hw_q <= '0;
      sv_pc_q <= '0;
    end else if (accept) begin
      pend_q  <= partial_d;
      sv_hw_q <= fetch_data_i[16*(FETCH_HW-1) +: 16];
      sv_pc_q <= base + AWTH'(2*(FETCH_HW-1));
    end
  end

  assign sj_vld = pend_q && (fetch_vaddr_i == sv_pc_q + AWTH'(2));
  assign sj_hw  = sv_hw_q;
  assign sj_pc  = sv_pc_q;
`else
  assign sj_vld = 1'b0;
  assign sj_hw  = '0;
  assign sj_pc  = '0;
`endif

  always_comb begin
    vld_d     = '0;
    is_c_d    = '0;
    neg_d     = '0;
    partial_d = 1'b0;
    cf_vld_d  = 1'b0;
    cf_idx_d  = '0;
    hw        = '0;
    imm       = '0;
    has_tgt   = 1'b0;
    cur       = {1'b0, ent_off};
    for (int k = 0; k < FETCH_HW; k++) begin
      instr_d[k] = '0;
      pc_d[k]    = base + AWTH'(2*k);
      tgt_d[k]   = '0;
      typ_d[k]   = QDEC_NORMAL;
    end
    // A joined straddle occupies slot 0 with the saved low half and its own pc.
    if (sj_vld) begin
      vld_d[0]   = 1'b1;
      instr_d[0] = IWTH'({fetch_data_i[15:0], sj_hw});
      pc_d[0]    = sj_pc;
      cur        = (OFFW+1)'(1);
    end
    for (int k = 0; k < FETCH_HW; k++) begin
      hw = dext[16*k +: 16];
      if (cur == (OFFW+1)'(k)) begin
        if (hw[1:0] != 2'b11) begin
          vld_d[k]   = 1'b1;
          is_c_d[k]  = 1'b1;
          instr_d[k] = IWTH'(hw);
          cur        = cur + (OFFW+1)'(1);
        end else if (k == FETCH_HW-1) begin
          partial_d = 1'b1;
        end else begin
          vld_d[k]   = 1'b1;
          instr_d[k] = IWTH'({dext[16*(k+1) +: 16], hw});
          cur        = cur + (OFFW+1)'(2);
        end
      end
    end
    for (int k = 0; k < FETCH_HW; k++) begin
      if (vld_d[k]) typ_d[k] = qdec_cls(instr_d[k], is_c_d[k]);
      imm     = qdec_imm(instr_d[k], is_c_d[k]);
      has_tgt = (typ_d[k] == QDEC_BRANCH) || (typ_d[k] == QDEC_JUMP) || (typ_d[k] == QDEC_CALL_JAL);
      if (has_tgt) begin
        tgt_d[k] = pc_d[k] + AWTH'(imm);
        neg_d[k] = imm[DWTH-1];
      end
    end
    for (int k = FETCH_HW-1; k >= 0; k--) begin
      if (vld_d[k] && typ_d[k] != QDEC_NORMAL) begin
        cf_vld_d = 1'b1;
        cf_idx_d = OFFW'(k);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      out_vld_q <= 1'b0;
      vld_q     <= '0;
      is_c_q    <= '0;
      neg_q     <= '0;
      instr_q   <= '0;
      pc_q      <= '0;
      tgt_q     <= '0;
      partial_q <= 1'b0;
      cf_vld_q  <= 1'b0;
      cf_idx_q  <= '0;
      for (int k = 0; k < FETCH_HW; k++) typ_q[k] <= QDEC_NORMAL;
    end else if (flush_i) begin
      out_vld_q <= 1'b0;
    end else if (accept) begin
      out_vld_q <= 1'b1;
      vld_q     <= vld_d;
      is_c_q    <= is_c_d;
      neg_q     <= neg_d;
      instr_q   <= instr_d;
      pc_q      <= pc_d;
      tgt_q     <= tgt_d;
      typ_q     <= typ_d;
      partial_q <= partial_d;
      cf_vld_q  <= cf_vld_d;
      cf_idx_q  <= cf_idx_d;
    end else if (out_rdy_i) begin
      out_vld_q <= 1'b0;
    end
  end

  assign out_vld_o      = out_vld_q;
  assign slot_vld_o     = vld_q;
  assign slot_instr_o   = instr_q;
  assign slot_pc_o      = pc_q;
  assign slot_is_c_o    = is_c_q;
  assign slot_imm_neg_o = neg_q;
  assign slot_type_o    = typ_q;
  assign slot_target_o  = tgt_q;
  assign cf_vld_o       = cf_vld_q;
  assign cf_idx_o       = cf_idx_q;
  assign partial_o      = partial_q;

endmodule

// File: doc/sy_ppl_qdec_blk.md
# sy_ppl_qdec_blk

Fetch-block quick decoder: scans one fetch block of `FETCH_HW` halfwords per transfer, finds every instruction boundary (RVI/RVC mix), classifies each as `qdec_type_e`, and computes per-slot PC-relative targets. Sits between the I-cache response and the fetch queue/branch predictor, replacing the single-instruction quick decoder. It adds a registered valid/ready output stage, entry-offset masking, and a straddle buffer for 32-bit instructions split across consecutive blocks.

## Interface
Parameters:
- `FETCH_HW`, 4: halfwords per fetch block; a power of 2, ≥2.
- `AWTH`, `IWTH`, `DWTH`: from `sy_pkg`.

Ports:
- `clk_i` in 1: clock.
- `rst_i` in 1: reset, synchronous, active-high.
- `flush_i` in 1: drop the output register and the straddle state.
- `fetch_vld_i` in 1: input block valid.
- `fetch_rdy_o` out 1: input accepted when `fetch_vld_i & fetch_rdy_o`.
- `fetch_data_i` in 16*FETCH_HW: block data; halfword k = bits [16k+15:16k].
- `fetch_vaddr_i` in AWTH: virtual address of the first useful halfword; bits [log2(FETCH_HW):1] give the entry offset.
- `out_vld_o` out 1 / `out_rdy_i` in 1: output handshake.
- `slot_vld_o` out FETCH_HW: slot k holds an instruction start.
- `slot_instr_o` out FETCH_HW×IWTH: instruction, RVC zero-extended.
- `slot_pc_o` out FETCH_HW×AWTH: instruction PC.
- `slot_is_c_o`, `slot_imm_neg_o` out FETCH_HW each.
- `slot_type_o` out FETCH_HW×`qdec_type_e`.
- `slot_target_o` out FETCH_HW×AWTH: pc+imm.
- `cf_vld_o` out 1 / `cf_idx_o` out log2(FETCH_HW): lowest valid slot whose type ≠ NORMAL.
- `partial_o` out 1: the last halfword begins a 32-bit instruction that is not emitted in this block.

## Operation
- Block base = `fetch_vaddr_i` with bits [log2(FETCH_HW):1] cleared. Start halfword s = offset. Halfwords below s are never slots.
- Scan from s. Halfword k is a start: if `hw[1:0]!=2'b11`, it is RVC and the next start is k+1; otherwise it is RVI, formed from {hw k+1, hw k}, and the next start is k+2.
- An RVI start at k=FETCH_HW-1 is a straddle. It gets no slot, `partial_o`=1, and {hw, pc} is saved as pending (see Configuration).
- Pending straddle with an accepted block where `fetch_vaddr_i == saved_pc+2`: slot 0 = {hw0, saved_hw}, pc = saved_pc, is_c=0, and the scan restarts at halfword 1.
- Pending straddle with a non-sequential block: the saved half is discarded and the block is decoded normally.
- Classification per slot uses these rules, with the same priority as the existing quick decoder:
  - RVC: ret → RET, c.jalr → CALL_JALR, c.j → JUMP, c.beqz/c.bnez → BRANCH, c.jr → JALR.
  - RVI: ret (rs1∈{x1,x5}, rd∉{x1,x5}) → RET, jalr with rd∈{x1,x5} → CALL_JALR, jal with rd∈{x1,x5} → CALL_JAL, jalr → JALR, jal → JUMP, branch → BRANCH.
- Immediates are DWTH sign-extended: RVC CJ/CB, RVI J/B. `slot_target_o` = pc + imm (AWTH wraparound) for BRANCH, JUMP and CALL_JAL; it is 0 for all other types. `slot_imm_neg_o` is the imm sign; it is 0 when the target is 0.
- Output register: `fetch_rdy_o = !out_vld_o | out_rdy_i`. An accepted block loads all slot fields and sets `out_vld_o`. Output fire without a new input clears `out_vld_o`. Fields are held stable while `out_vld_o & !out_rdy_i`.
- Straddle state updates only on input accept.

## Timing
- Latency: 1 cycle from input accept to `out_vld_o`. Throughput is one block per cycle.
- Reset: `out_vld_o`=0, every slot field=0, `cf_vld_o`=0, `cf_idx_o`=0, `partial_o`=0, straddle cleared. `fetch_rdy_o` reads 1 in the first cycle after reset.
- `flush_i` wins over a simultaneous accept. The input is dropped, and the next cycle has `out_vld_o`=0 and straddle cleared. `fetch_rdy_o` is not gated by `flush_i`.
- Reset during a stall discards the held output.

## Configuration
- `SY_QDEC_STRADDLE_EN` defined: straddle buffer built; behaviour as above.
- Not defined: no straddle state. A straddling halfword only sets `partial_o`. The next block is always decoded from its own entry offset, and fetch must re-fetch at pc of the straddling instruction.

## Test plan
- FETCH_HW=4, vaddr 0x80000000, four `0x0001` (c.nop) → one cycle later `slot_vld_o`=4'b1111, `slot_is_c_o`=4'b1111, all NORMAL, `cf_vld_o`=0.
- Halfwords 0–1 = 0x100000EF (jal x1,+0x100), hw2 = 0x8082 (c.jr ra), hw3 = 0x0001 → slot_vld=4'b1101. Slot0 is CALL_JAL with target 0x80000100, slot2 is RET at pc 0x80000004, `cf_idx_o`=0.
- Straddle: hw3 = 0x0463 at 0x80000000, then block 0x80000008 with hw0=0x0000 → first output `partial_o`=1, slot3 invalid. Second output: slot0 pc 0x80000006, BRANCH, target 0x8000000E.
- Straddle pending, next block at 0x80001000 → saved half discarded, slot0 is decoded from that block's hw0 at pc 0x80001000.
- Entry vaddr 0x80000004 with four c.nop → slot_vld=4'b1100, slot2 pc 0x80000004.
- `out_rdy_i`=0 for 3 cycles with valid output → fields stable, `fetch_rdy_o`=0. Then pulse `flush_i` → `out_vld_o`=0 next cycle, straddle cleared.
